// File: rtl/paddle_controller_pkg.sv
// Shared VGA geometry, paddle FSM state type and the saturating position step.
// Used by both the display and control logic.
package paddle_controller_pkg;

    localparam int V_VISIBLE_AREA = 480;
    localparam int PADDLE_WIDTH   = 10;
    localparam int PADDLE_HEIGHT  = 50;
    localparam int Y_MAX          = V_VISIBLE_AREA - PADDLE_HEIGHT;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } state_t;

    // 10-bit arithmetic so neither direction can wrap before the clamp.
    function automatic logic [8:0] step_y(input logic [8:0] y,
                                          input logic [3:0] spd,
                                          input logic       up);
        logic [9:0] y10;
        logic [9:0] s10;
        logic [9:0] sum;
        logic [8:0] res;
        y10 = {1'b0, y};
        s10 = {6'd0, spd};
        sum = y10 + s10;
        if (up)
            res = (y10 >= s10) ? y[8:0] - {5'd0, spd} : 9'd0;
        else
            res = (sum > 10'(Y_MAX)) ? 9'(Y_MAX) : sum[8:0];
        return res;
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a stable-level counter; the output follows
// the input only after it has differed for p_CYCLES consecutive cycles.
module debounce #(
    parameter int p_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(p_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(p_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/paddle_controller.sv
// Paddle position controller: debounced buttons drive an IDLE/MOVE_UP/MOVE_DOWN
// FSM stepped once per frame. Define PADDLE_ACCEL_EN for speed ramping.
module paddle_controller
    import paddle_controller_pkg::*;
#(
    parameter int p_START_Y         = 200,
    parameter int p_DEBOUNCE_CYCLES = 250000,
    parameter int p_MAX_SPEED       = 8,
    parameter int p_RAMP_FRAMES     = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_VBlank,
    input  logic       i_Up,
    input  logic       i_Down,
    output logic [8:0] o_Y,
    output logic [3:0] o_Speed,
    output logic       o_Moving
);

    logic   up_db;
    logic   down_db;
    logic   vblank_d;
    logic   frame_tick;
    state_t state;
    state_t state_next;
    logic [3:0] spd_next;

    debounce #(.p_CYCLES(p_DEBOUNCE_CYCLES)) u_up_db (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .raw   (i_Up),
        .level (up_db)
    );

    debounce #(.p_CYCLES(p_DEBOUNCE_CYCLES)) u_down_db (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .raw   (i_Down),
        .level (down_db)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vblank_d   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vblank_d   <= i_VBlank;
            frame_tick <= i_VBlank & ~vblank_d;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (up_db && !down_db)
            state_next = MOVE_UP;
        else if (down_db && !up_db)
            state_next = MOVE_DOWN;
    end

`ifdef PADDLE_ACCEL_EN
    localparam int RAMP_W = (p_RAMP_FRAMES > 1) ? $clog2(p_RAMP_FRAMES) : 1;

    logic [RAMP_W-1:0] ramp;
    logic [RAMP_W-1:0] ramp_next;

    // Ramp counts frames spent at the current speed within one MOVE state.
    always_comb begin
        spd_next  = o_Speed;
        ramp_next = ramp;
        if (state_next == IDLE) begin
            spd_next  = 4'd0;
            ramp_next = '0;
        end else if (state_next != state) begin
            spd_next  = 4'd1;
            ramp_next = '0;
        end else if (ramp == RAMP_W'(p_RAMP_FRAMES - 1)) begin
            ramp_next = '0;
            if (o_Speed < 4'(p_MAX_SPEED))
                spd_next = o_Speed + 4'd1;
        end else begin
            ramp_next = ramp + 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            ramp <= '0;
        else if (frame_tick)
            ramp <= ramp_next;
    end
`else
    always_comb begin
        spd_next = (state_next == IDLE) ? 4'd0 : 4'd1;
    end
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            o_Y      <= 9'(p_START_Y);
            o_Speed  <= 4'd0;
            o_Moving <= 1'b0;
        end else if (frame_tick) begin
            state    <= state_next;
            o_Speed  <= spd_next;
            o_Moving <= (state_next != IDLE);
            if (state_next != IDLE)
                o_Y <= step_y(o_Y, spd_next, state_next == MOVE_UP);
        end
    end

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller with a 4-cycle debounce window.
// Expectations adapt to whether PADDLE_ACCEL_EN is defined.
module tb_paddle_controller;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       vblank = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [8:0] y;
    logic [3:0] speed;
    logic       moving;

    int vectors = 0;
    int miscompares = 0;

    paddle_controller #(
        .p_START_Y         (200),
        .p_DEBOUNCE_CYCLES (4),
        .p_MAX_SPEED       (8),
        .p_RAMP_FRAMES     (4)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_l),
        .i_VBlank (vblank),
        .i_Up     (up),
        .i_Down   (down),
        .o_Y      (y),
        .o_Speed  (speed),
        .o_Moving (moving)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       up;
        logic       down;
        int         y;
        int         spd;
        int         mv;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        vblank = 1'b1;
        repeat (2) @(negedge clk);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        up = 1'b0;
        down = 1'b0;
        rst_l = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);
    endtask

    function automatic int accel_speed(input int frame_idx);
`ifdef PADDLE_ACCEL_EN
        return (frame_idx / 4) + 1;
`else
        return (frame_idx >= 0) ? 1 : 1;
`endif
    endfunction

    initial begin
        int yexp;
        int y0;
        bit hit;
        bit over;

        vecs[0] = '{1'b0, 1'b0, 200, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 199, 1, 1};
        vecs[2] = '{1'b1, 1'b0, 198, 1, 1};
        vecs[3] = '{1'b1, 1'b1, 198, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 199, 1, 1};
        vecs[5] = '{1'b0, 1'b1, 200, 1, 1};
        vecs[6] = '{1'b1, 1'b0, 199, 1, 1};
        vecs[7] = '{1'b0, 1'b0, 199, 0, 0};
        vecs[8] = '{1'b0, 1'b1, 200, 1, 1};

        // Reset state while held in reset
        repeat (2) @(negedge clk);
        chk("reset_y", int'(y), 200);
        chk("reset_speed", int'(speed), 0);
        chk("reset_moving", int'(moving), 0);
        rst_l = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            up = vecs[i].up;
            down = vecs[i].down;
            settle();
            frame();
            chk($sformatf("vec%0d_y", i), int'(y), vecs[i].y);
            chk($sformatf("vec%0d_speed", i), int'(speed), vecs[i].spd);
            chk($sformatf("vec%0d_moving", i), int'(moving), vecs[i].mv);
        end

        // No frame ticks: position held despite button changes
        do_reset();
        up = 1'b1;
        settle();
        down = 1'b1;
        settle();
        up = 1'b0;
        settle();
        chk("hold_no_tick_y", int'(y), 200);
        chk("hold_no_tick_moving", int'(moving), 0);

        // Debounce: a 3-cycle glitch is ignored, a 10-cycle press is accepted
        do_reset();
        up = 1'b1;
        repeat (3) @(negedge clk);
        up = 1'b0;
        settle();
        frame();
        chk("glitch_y", int'(y), 200);
        chk("glitch_moving", int'(moving), 0);
        up = 1'b1;
        settle();
        frame();
        chk("press_y", int'(y), 199);
        chk("press_speed", int'(speed), 1);

        // Asynchronous reset mid-move, then first tick after release is idle
        frame();
        @(posedge clk);
        #3 rst_l = 1'b0;
        #1;
        chk("async_rst_y", int'(y), 200);
        chk("async_rst_speed", int'(speed), 0);
        chk("async_rst_moving", int'(moving), 0);
        @(negedge clk);
        rst_l = 1'b1;
        frame();
        chk("post_rst_tick_y", int'(y), 200);
        chk("post_rst_tick_moving", int'(moving), 0);
        settle();
        frame();
        chk("post_rst_move_y", int'(y), 199);

        // Acceleration profile over 12 frames of down
        do_reset();
        down = 1'b1;
        settle();
        yexp = 200;
        for (int f = 0; f < 12; f++) begin
            frame();
            yexp += accel_speed(f);
            chk($sformatf("accel_f%0d_speed", f), int'(speed), accel_speed(f));
        end
        chk("accel_final_y", int'(y), yexp);
`ifdef PADDLE_ACCEL_EN
        chk("accel_final_y_abs", int'(y), 224);
`else
        chk("accel_final_y_abs", int'(y), 212);
`endif

        // Both buttons held: idle and stationary for 3 frames
        up = 1'b1;
        settle();
        y0 = int'(y);
        for (int f = 0; f < 3; f++) begin
            frame();
            chk($sformatf("both_f%0d_y", f), int'(y), y0);
            chk($sformatf("both_f%0d_speed", f), int'(speed), 0);
            chk($sformatf("both_f%0d_moving", f), int'(moving), 0);
        end

        // Reversal from down (speed 2 when ramping) to up restarts at speed 1
        do_reset();
        down = 1'b1;
        settle();
        for (int f = 0; f < 5; f++) frame();
        chk("rev_pre_speed", int'(speed), accel_speed(4));
        y0 = int'(y);
        down = 1'b0;
        up = 1'b1;
        settle();
        frame();
        chk("rev_speed", int'(speed), 1);
        chk("rev_y", int'(y), y0 - 1);
        chk("rev_moving", int'(moving), 1);

        // Clamp at top: reach 0, stay there while still in MOVE_UP
        hit = 1'b0;
        for (int f = 0; f < 260 && !hit; f++) begin
            frame();
            if (y == 9'd0) hit = 1'b1;
        end
        chk("clamp_top_reached", int'(hit), 1);
        for (int f = 0; f < 3; f++) begin
            frame();
            chk($sformatf("clamp_top_f%0d_y", f), int'(y), 0);
            chk($sformatf("clamp_top_f%0d_moving", f), int'(moving), 1);
        end

        // Clamp at bottom: reach 430, never exceed it, stay there
        up = 1'b0;
        down = 1'b1;
        settle();
        hit = 1'b0;
        over = 1'b0;
        for (int f = 0; f < 500 && !hit; f++) begin
            frame();
            if (y > 9'd430) over = 1'b1;
            if (y == 9'd430) hit = 1'b1;
        end
        chk("clamp_bot_reached", int'(hit), 1);
        chk("clamp_bot_no_overshoot", int'(over), 0);
        for (int f = 0; f < 3; f++) begin
            frame();
            chk($sformatf("clamp_bot_f%0d_y", f), int'(y), 430);
            chk($sformatf("clamp_bot_f%0d_moving", f), int'(moving), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
